// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control, target and status bundle for the program-counter stage.
//   Control in : PCWrite, PCWriteCond, Zero, Stall, PCSource[1:0]
//   Targets in : JumpTarget, BranchOffset, AccIn (WIDTH bits each)
//   Status out : PC, OldPC, PCPlusInc (WIDTH bits), PCTopBits[1:0], Redirect, FetchValid
// The master modport belongs to control and datapath. The slave modport belongs to pc_sequencer.
interface pc_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             PCWrite;
   logic             PCWriteCond;
   logic             Zero;
   logic             Stall;
   logic [1:0]       PCSource;
   logic [WIDTH-1:0] JumpTarget;
   logic [WIDTH-1:0] BranchOffset;
   logic [WIDTH-1:0] AccIn;
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] OldPC;
   logic [1:0]       PCTopBits;
   logic [WIDTH-1:0] PCPlusInc;
   logic             Redirect;
   logic             FetchValid;

   modport master (
      output PCWrite, PCWriteCond, Zero, Stall, PCSource, JumpTarget, BranchOffset, AccIn,
      input  PC, OldPC, PCTopBits, PCPlusInc, Redirect, FetchValid
   );

   modport slave (
      input  PCWrite, PCWriteCond, Zero, Stall, PCSource, JumpTarget, BranchOffset, AccIn,
      output PC, OldPC, PCTopBits, PCPlusInc, Redirect, FetchValid
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage of the 16-bit accumulator processor.
// The stage holds PC and OldPC. It picks the next PC from one of four sources:
// PC+INC, the jump target, OldPC+branch offset, or the accumulator.
// A small FSM marks the fetch as invalid after reset and for one cycle after
// each non-sequential update.
// Ports:
//   CLK   - system clock; all state changes on the rising edge
//   Reset - synchronous active-low reset
//   bus   - pc_sequencer_if.slave carrying the control inputs, the targets and the PC status
module pc_sequencer #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               INC          = 2
) (
   input logic           CLK,
   input logic           Reset,
   pc_sequencer_if.slave bus
);
   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, old_q, next_pc;
   logic             redirect_q;
   logic             we, redir_we, fetch_valid;

   // Stall overrides both write requests. The cond path needs Zero.
   assign we       = ~bus.Stall & (bus.PCWrite | (bus.PCWriteCond & bus.Zero));
   assign redir_we = we & (bus.PCSource != 2'b00);

   // All of the sums wrap modulo 2^WIDTH. Nothing flags an overflow.
   always_comb begin
      next_pc = pc_q + INC_W;
      case (bus.PCSource)
         2'b01:   next_pc = bus.JumpTarget;
         2'b10:   next_pc = old_q + bus.BranchOffset;
         2'b11:   next_pc = bus.AccIn;
         default: next_pc = pc_q + INC_W;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         pc_q       <= RESET_VECTOR;
         old_q      <= RESET_VECTOR;
         redirect_q <= 1'b0;
         state_q    <= BOOT;
      end else begin
         redirect_q <= redir_we;
         state_q    <= state_d;
         if (we) begin
            pc_q  <= next_pc;
            old_q <= pc_q;
         end
      end
   end

   // A stall freezes the state, so FetchValid keeps its value.
   // On any unstalled edge, a committed redirect from any state (BOOT, RUN
   // or FLUSH) moves to FLUSH. Any other unstalled edge moves to RUN.
   always_comb begin
      state_d     = state_q;
      fetch_valid = 1'b0;
      case (state_q)
         BOOT: begin
            fetch_valid = 1'b0;
            if (!bus.Stall) state_d = redir_we ? FLUSH : RUN;
         end
         RUN: begin
            fetch_valid = 1'b1;
            if (redir_we) state_d = FLUSH;
         end
         FLUSH: begin
            fetch_valid = 1'b0;
            if (!bus.Stall) state_d = redir_we ? FLUSH : RUN;
         end
         default: begin
            fetch_valid = 1'b0;
            state_d     = BOOT;
         end
      endcase
   end

   assign bus.PC         = pc_q;
   assign bus.OldPC      = old_q;
   assign bus.PCTopBits  = pc_q[WIDTH-1:WIDTH-2];
   assign bus.PCPlusInc  = pc_q + INC_W;
   assign bus.Redirect   = redirect_q;
   assign bus.FetchValid = fetch_valid;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus for pc_sequencer, checked against a
// cycle-level behavioural model of the PC, OldPC, Redirect and fetch-valid rules.
module tb_pc_sequencer;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   logic [15:0] m_pc, m_old;
   logic        m_red, m_fv;

   pc_sequencer_if #(.WIDTH(16)) bus();

   pc_sequencer #(.WIDTH(16), .RESET_VECTOR(16'h0000), .INC(2)) dut (
      .CLK  (clk),
      .Reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model one edge from the current inputs, let the DUT take the edge, then compare.
   task automatic tick();
      logic        we;
      logic [15:0] nxt;
      we = !bus.Stall && (bus.PCWrite || (bus.PCWriteCond && bus.Zero));
      case (bus.PCSource)
         2'd0:    nxt = m_pc + 16'd2;
         2'd1:    nxt = bus.JumpTarget;
         2'd2:    nxt = m_old + bus.BranchOffset;
         default: nxt = bus.AccIn;
      endcase
      if (!reset) begin
         m_pc = 16'h0; m_old = 16'h0; m_red = 1'b0; m_fv = 1'b0;
      end else if (bus.Stall) begin
         m_red = 1'b0;
      end else begin
         m_red = we && (bus.PCSource != 2'd0);
         m_fv  = !m_red;
         if (we) begin
            m_old = m_pc;
            m_pc  = nxt;
         end
      end
      @(posedge clk);
      #1;
      chk("pc", bus.PC, m_pc);
      chk("oldpc", bus.OldPC, m_old);
      chk("redirect", {15'd0, bus.Redirect}, {15'd0, m_red});
      chk("fetchvalid", {15'd0, bus.FetchValid}, {15'd0, m_fv});
      chk("topbits", {14'd0, bus.PCTopBits}, {14'd0, m_pc[15:14]});
      chk("plusinc", bus.PCPlusInc, m_pc + 16'd2);
   endtask

   task automatic idle();
      bus.PCWrite = 0; bus.PCWriteCond = 0; bus.Stall = 0; bus.Zero = 0; bus.PCSource = 2'd0;
   endtask

   task automatic jump(input logic [15:0] t);
      idle();
      bus.PCWrite = 1; bus.PCSource = 2'd1; bus.JumpTarget = t;
      tick();
      idle();
   endtask

   initial begin
      errors = 0; checks = 0;
      m_pc = 0; m_old = 0; m_red = 0; m_fv = 0;
      reset = 0;
      idle();
      bus.JumpTarget = 0; bus.BranchOffset = 0; bus.AccIn = 0;

      // Reset for two cycles while requesting sequential writes
      bus.PCWrite = 1;
      tick(); tick();
      chk("rst_pc", bus.PC, 16'h0000);
      chk("rst_fv", {15'd0, bus.FetchValid}, 16'd0);
      reset = 1;
      tick(); chk("step1", bus.PC, 16'h0002);
      chk("fv_after_boot", {15'd0, bus.FetchValid}, 16'd1);
      tick(); chk("step2", bus.PC, 16'h0004);
      tick(); chk("step3", bus.PC, 16'h0006);

      // Jump from 0x4010 to 0x4A20
      jump(16'h4010); tick();
      chk("top_before", {14'd0, bus.PCTopBits}, 16'd1);
      bus.PCWrite = 1; bus.PCSource = 2'd1; bus.JumpTarget = 16'h4A20;
      tick();
      chk("jmp_pc", bus.PC, 16'h4A20);
      chk("jmp_old", bus.OldPC, 16'h4010);
      chk("jmp_red", {15'd0, bus.Redirect}, 16'd1);
      chk("jmp_fv", {15'd0, bus.FetchValid}, 16'd0);
      chk("top_after", {14'd0, bus.PCTopBits}, 16'd1);
      idle(); tick();
      chk("jmp_red_end", {15'd0, bus.Redirect}, 16'd0);

      // Conditional branch off OldPC=0x0100
      jump(16'h0100);
      bus.PCWrite = 1; tick(); idle();
      chk("br_base", bus.OldPC, 16'h0100);
      bus.PCWriteCond = 1; bus.PCSource = 2'd2; bus.BranchOffset = 16'hFFF0;
      tick();
      chk("br_nz", bus.PC, 16'h0102);
      bus.Zero = 1; tick();
      chk("br_z", bus.PC, 16'h00F0);
      idle();

      // Increment wraps at the top of the address space
      jump(16'hFFFE);
      bus.PCWrite = 1; tick();
      chk("wrap_pc", bus.PC, 16'h0000);
      chk("wrap_red", {15'd0, bus.Redirect}, 16'd0);
      idle();

      // A stall holds state even with a write requested
      jump(16'h0020); tick();
      bus.Stall = 1; bus.PCWrite = 1; bus.PCSource = 2'd3; bus.AccIn = 16'h1234;
      repeat (3) tick();
      chk("stall_pc", bus.PC, 16'h0020);
      bus.Stall = 0; tick();
      chk("acc_pc", bus.PC, 16'h1234);

      // Reset during FLUSH
      jump(16'h2222);
      reset = 0; tick();
      chk("rf_pc", bus.PC, 16'h0000);
      chk("rf_fv", {15'd0, bus.FetchValid}, 16'd0);
      reset = 1; tick();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         reset            = ($urandom_range(0, 39) != 0);
         bus.PCWrite      = $urandom_range(0, 1);
         bus.PCWriteCond  = $urandom_range(0, 1);
         bus.Zero         = $urandom_range(0, 1);
         bus.Stall        = ($urandom_range(0, 4) == 0);
         bus.PCSource     = 2'($urandom_range(0, 3));
         bus.JumpTarget   = 16'($urandom);
         bus.BranchOffset = 16'($urandom);
         bus.AccIn        = 16'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
